// File: rtl/calc_pkg.sv
// ============================================================================
// calc_pkg : shared key codes, ALU op encodings and sequencer state encoding
// Revision : 1.0
// ============================================================================
`default_nettype none

package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_DIV = 4'hC;
  localparam logic [3:0] KEY_MUL = 4'hD;
  localparam logic [3:0] KEY_CLR = 4'hE;
  localparam logic [3:0] KEY_EQ  = 4'hF;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_DIV = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [63:0] ALL_ONES = '1;

  typedef enum logic [2:0] {
    ST_ENTER_A = 3'd0,
    ST_ENTER_B = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_SHOW    = 3'd4,
    ST_ERR     = 3'd5
  } state_e;

  // Operator keys A..D map in order onto the ALU op encodings.
  function automatic logic [1:0] key_to_op(input logic [3:0] key);
    logic [3:0] offs;
    offs = key - KEY_ADD;
    return offs[1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/calc_digit_accum.sv
// ============================================================================
// calc_digit_accum : decimal operand accumulator (acc*10+d) with digit limit
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_digit_accum #(
  parameter int WIDTH      = 32,
  parameter int MAX_DIGITS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             push_i,
  input  logic [3:0]       digit_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             has_digit_o
);

  localparam int              CNT_W   = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (load_i) begin
      acc_d = WIDTH'(digit_i);
      cnt_d = CNT_W'(1);
    end else if (push_i && (cnt_q < CNT_MAX)) begin
      acc_d = (acc_q * WIDTH'(10)) + WIDTH'(digit_i);
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign acc_o       = acc_q;
  assign acc_next_o  = acc_d;
  assign has_digit_o = (cnt_q != '0);

endmodule

`default_nettype wire

// File: rtl/calc_op_sequencer.sv
// ============================================================================
// calc_op_sequencer : keypad-driven operand builder and ALU transaction FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module calc_op_sequencer
  import calc_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MAX_DIGITS  = 9,
  parameter int ALU_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] answer,
  output logic             error,
  output logic             busy
);

  localparam int               TW       = $clog2(ALU_TIMEOUT + 1);
  localparam logic [TW-1:0]    TMO_LAST = TW'(ALU_TIMEOUT - 1);
  localparam logic [WIDTH-1:0] ERR_CODE = ALL_ONES[WIDTH-1:0];

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, answer_q, answer_d;
  logic [1:0]       op_q, op_d, nop_q, nop_d;
  logic             nop_vld_q, nop_vld_d;
  logic             error_q, error_d;
  logic             start_q, start_d;
  logic [TW-1:0]    timer_q, timer_d;

  logic             acc_clear, acc_load, acc_push;
  logic [WIDTH-1:0] acc, acc_next;
  logic             has_digit;

  logic       key_clr, key_dig, key_op, key_eq;
  logic [1:0] key_op_enc;

  assign key_clr    = key_valid && (key_code == KEY_CLR);
  assign key_eq     = key_valid && (key_code == KEY_EQ);
  assign key_dig    = key_valid && (key_code <= 4'd9);
  assign key_op     = key_valid && (key_code >= KEY_ADD) && (key_code <= KEY_MUL);
  assign key_op_enc = key_to_op(key_code);

  calc_digit_accum #(
    .WIDTH      (WIDTH),
    .MAX_DIGITS (MAX_DIGITS)
  ) u_accum (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (acc_clear),
    .load_i      (acc_load),
    .push_i      (acc_push),
    .digit_i     (key_code),
    .acc_o       (acc),
    .acc_next_o  (acc_next),
    .has_digit_o (has_digit)
  );

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    nop_d     = nop_q;
    nop_vld_d = nop_vld_q;
    answer_d  = answer_q;
    error_d   = error_q;
    timer_d   = timer_q;
    start_d   = 1'b0;
    acc_clear = 1'b0;
    acc_load  = 1'b0;
    acc_push  = 1'b0;

    // Clear beats everything, including a coincident alu_done.
    if (key_clr) begin
      state_d   = ST_ENTER_A;
      acc_clear = 1'b1;
      a_d       = '0;
      b_d       = '0;
      answer_d  = '0;
      error_d   = 1'b0;
      nop_vld_d = 1'b0;
      timer_d   = '0;
    end else begin
      case (state_q)
        ST_ENTER_A, ST_ENTER_B: begin
          if (key_dig) begin
            acc_push = 1'b1;
            answer_d = acc_next;
            error_d  = 1'b0;
          end else if (key_op && (state_q == ST_ENTER_A)) begin
            a_d       = acc;
            op_d      = key_op_enc;
            acc_clear = 1'b1;
            state_d   = ST_ENTER_B;
          end else if (key_op && !has_digit) begin
            op_d = key_op_enc;
          end else if (key_op) begin
            b_d       = acc;
            nop_d     = key_op_enc;
            nop_vld_d = 1'b1;
            acc_clear = 1'b1;
            state_d   = ST_ISSUE;
          end else if (key_eq && (state_q == ST_ENTER_B)) begin
            b_d       = has_digit ? acc : a_q;
            nop_vld_d = 1'b0;
            acc_clear = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if ((op_q == OP_DIV) && (b_q == '0)) begin
            answer_d  = ERR_CODE;
            error_d   = 1'b1;
            nop_vld_d = 1'b0;
            state_d   = ST_ERR;
          end else begin
            start_d = 1'b1;
            timer_d = '0;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (alu_done) begin
            answer_d = alu_result;
            a_d      = alu_result;
            if (nop_vld_q) begin
              op_d      = nop_q;
              nop_vld_d = 1'b0;
              state_d   = ST_ENTER_B;
            end else begin
              state_d = ST_SHOW;
            end
          end else if (timer_q == TMO_LAST) begin
            answer_d  = ERR_CODE;
            error_d   = 1'b1;
            nop_vld_d = 1'b0;
            state_d   = ST_ERR;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        ST_SHOW, ST_ERR: begin
          if (key_dig) begin
            acc_load = 1'b1;
            answer_d = acc_next;
            error_d  = 1'b0;
            state_d  = ST_ENTER_A;
          end else if (key_op && (state_q == ST_SHOW)) begin
            op_d      = key_op_enc;
            acc_clear = 1'b1;
            state_d   = ST_ENTER_B;
          end else if (key_eq && (state_q == ST_SHOW)) begin
            state_d = ST_ISSUE;
          end
        end
        default: state_d = ST_ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= OP_ADD;
      nop_q     <= OP_ADD;
      nop_vld_q <= 1'b0;
      answer_q  <= '0;
      error_q   <= 1'b0;
      start_q   <= 1'b0;
      timer_q   <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      nop_q     <= nop_d;
      nop_vld_q <= nop_vld_d;
      answer_q  <= answer_d;
      error_q   <= error_d;
      start_q   <= start_d;
      timer_q   <= timer_d;
    end
  end

  assign alu_start = start_q && !key_clr;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign answer    = answer_q;
  assign error     = error_q;
  assign busy      = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

endmodule

`default_nettype wire
